fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/fifo_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
//
// Purpose: holds the arbiter state enumeration and the default burst length
// so the arbiter and anything that inspects it agree on one encoding.
// Ports: none (package).

package fifo_arb_pkg;

  // Arbiter FSM states: IDLE owns nothing, SERVEk owns the FIFO write port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } arb_state_e;

  // Default maximum number of consecutive beats per grant (legal 1..15).
  localparam int unsigned DEFAULT_MAX_BURST = 4;

  // Burst counter width; wide enough for MAX_BURST-1 up to 14.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO used as the arbiter's downstream load
//
// Purpose: plain synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   wr_en_i     write request; ignored while full_o
//   wdata_i     write data
//   full_o      FIFO holds DEPTH entries
//   wr_error_o  write requested while full (flags an upstream protocol fault)
//   rd_en_i     read request; ignored while empty_o
//   rdata_o     head-of-queue data, valid while !empty_o
//   empty_o     FIFO holds no entries

module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             wr_error_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  // DEPTH is expected to be a power of two so the pointers wrap naturally.
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr;
  logic             do_rd;

  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == '0);
  assign do_wr      = wr_en_i && !full_o;
  assign do_rd      = rd_en_i && !empty_o;
  assign wr_error_o = wr_en_i && full_o;
  assign rdata_o    = mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - two-requester burst arbiter for one FIFO write port
//
// Purpose: shares a single FIFO write port between two requesters. A grant
// lasts until its requester drops or MAX_BURST beats have been written; ties
// from IDLE go to the requester not served last. Stalls while the FIFO is
// full without losing the grant.
// Ports:
//   clk_i               clock, rising edge
//   rst_i               asynchronous active-high reset
//   req0_i / req1_i     requester k has a word this cycle
//   wdata0_i / wdata1_i requester k write data
//   gnt0_o / gnt1_o     requester k owns the write port (registered state)
//   full_i              FIFO full flag
//   wr_en_o             FIFO write enable, high exactly on beat cycles
//   wdata_o             FIFO write data, muxed from the granted requester
//   busy_o              arbiter is not IDLE

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] wdata0_i,
  input  logic [WIDTH-1:0] wdata1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  input  logic             full_i,
  output logic             wr_en_o,
  output logic [WIDTH-1:0] wdata_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_q;
  logic             last_d;

  logic             own_req;
  logic             other_req;
  arb_state_e       other_state;
  logic             beat;
  logic             burst_end;

  // Request of the current owner and of the opposite requester. In IDLE
  // neither applies, which keeps beat (and hence wr_en_o) low there.
  always_comb begin
    own_req     = 1'b0;
    other_req   = 1'b0;
    other_state = IDLE;
    case (state_q)
      SERVE0: begin
        own_req     = req0_i;
        other_req   = req1_i;
        other_state = SERVE1;
      end
      SERVE1: begin
        own_req     = req1_i;
        other_req   = req0_i;
        other_state = SERVE0;
      end
      default: begin
        own_req     = 1'b0;
        other_req   = 1'b0;
        other_state = IDLE;
      end
    endcase
  end

  // A beat needs grant, request and room; all are gated here so no write can
  // reach the FIFO while full or without a live request.
  assign beat      = own_req && !full_i;
  assign burst_end = beat && (cnt_q == LAST_BEAT);

  assign gnt0_o  = (state_q == SERVE0);
  assign gnt1_o  = (state_q == SERVE1);
  assign busy_o  = (state_q != IDLE);
  assign wr_en_o = beat;

  always_comb begin
    wdata_o = '0;
    case (state_q)
      SERVE0:  wdata_o = wdata0_i;
      SERVE1:  wdata_o = wdata1_i;
      default: wdata_o = '0;
    endcase
  end

  // Next-state, burst counter and last-served pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0_i && req1_i) begin
          // last_q==1 means requester 1 was served last, so 0 wins the tie.
          state_d = last_q ? SERVE0 : SERVE1;
        end else if (req0_i) begin
          state_d = SERVE0;
        end else if (req1_i) begin
          state_d = SERVE1;
        end
      end

      SERVE0, SERVE1: begin
        if (!own_req) begin
          // Owner dropped: hand over directly or fall back to IDLE.
          state_d = other_req ? other_state : IDLE;
          cnt_d   = '0;
        end else if (burst_end) begin
          // Same-cycle handoff when the other side waits; otherwise re-grant
          // the current owner with a fresh burst.
          state_d = other_req ? other_state : state_q;
          cnt_d   = '0;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
        // full_i with a live request: state and counter hold.
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == SERVE0) begin
      last_d = 1'b0;
    end else if (state_d == SERVE1) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with a FIFO load

module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0, req1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, full, wr_en, busy;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             empty, wr_error;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req0_i  (req0),
    .req1_i  (req1),
    .wdata0_i(wdata0),
    .wdata1_i(wdata1),
    .gnt0_o  (gnt0),
    .gnt1_o  (gnt1),
    .full_i  (full),
    .wr_en_o (wr_en),
    .wdata_o (wdata),
    .busy_o  (busy)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wdata_i   (wdata),
    .full_o    (full),
    .wr_error_o(wr_error),
    .rd_en_i   (rd_en),
    .rdata_o   (rdata),
    .empty_o   (empty)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit               g0;
    bit               g1;
    bit               busy;
    bit               beat;
    bit               full;
    logic [WIDTH-1:0] wd;
  } cyc_t;

  typedef struct {
    int               src;
    logic [WIDTH-1:0] data;
  } beat_t;

  cyc_t  cyc_q[$];
  beat_t beat_q[$];

  // Reference model: owner -1/0/1, beats written in the current grant,
  // who was granted most recently, and the FIFO contents as a queue.
  int               owner    = -1;
  int               beats    = 0;
  int               last     = 1;
  int               beat_src = -1;
  logic [WIDTH-1:0] fifo_q[$];

  // Requester word queues and stimulus knobs.
  logic [WIDTH-1:0] rq0[$];
  logic [WIDTH-1:0] rq1[$];
  bit               en0 = 0, en1 = 0, rnd_mode = 0;
  int               rd_pct = 0;

  task automatic model_reset();
    owner = -1;
    beats = 0;
    last  = 1;
    fifo_q.delete();
  endtask

  // Evaluated once per cycle at the falling edge with inputs stable.
  task automatic model_step();
    cyc_t             e;
    beat_t            b;
    bit               r[2];
    logic [WIDTH-1:0] d[2];
    bit               f;
    int               other;
    r[0] = req0; r[1] = req1;
    d[0] = wdata0; d[1] = wdata1;
    beat_src = -1;
    if (rst) begin
      model_reset();
      e.g0 = 0; e.g1 = 0; e.busy = 0; e.beat = 0; e.full = 0; e.wd = '0;
      cyc_q.push_back(e);
      return;
    end
    f      = (fifo_q.size() == DEPTH);
    e.g0   = (owner == 0);
    e.g1   = (owner == 1);
    e.busy = (owner != -1);
    e.full = f;
    e.wd   = (owner >= 0) ? d[owner] : '0;
    e.beat = (owner >= 0) && r[owner] && !f;
    if (rd_en && fifo_q.size() > 0) begin
      chk("fifo_rdata", 32'(rdata), 32'(fifo_q[0]));
      fifo_q.delete(0);
    end
    if (e.beat) begin
      b.src  = owner;
      b.data = d[owner];
      beat_q.push_back(b);
      fifo_q.push_back(d[owner]);
      beat_src = owner;
    end
    cyc_q.push_back(e);

    if (owner == -1) begin
      if (r[0] && r[1])  owner = (last == 1) ? 0 : 1;
      else if (r[0])     owner = 0;
      else if (r[1])     owner = 1;
      beats = 0;
    end else begin
      other = 1 - owner;
      if (!r[owner]) begin
        owner = r[other] ? other : -1;
        beats = 0;
      end else if (e.beat) begin
        beats++;
        if (beats == MAX_BURST) begin
          beats = 0;
          if (r[other]) owner = other;
        end
      end
    end
    if (owner != -1) last = owner;
  endtask

  task automatic drive();
    req0   = en0 && (rq0.size() > 0);
    req1   = en1 && (rq1.size() > 0);
    wdata0 = (rq0.size() > 0) ? rq0[0] : 8'($urandom);
    wdata1 = (rq1.size() > 0) ? rq1[0] : 8'($urandom);
    rd_en  = ($urandom_range(0, 99) < rd_pct);
  endtask

  task automatic stim_update();
    if (beat_src == 0) rq0.delete(0);
    if (beat_src == 1) rq1.delete(0);
    if (rnd_mode) begin
      en0 = ($urandom_range(0, 9) < 8);
      en1 = ($urandom_range(0, 9) < 7);
      if (rq0.size() < 3) rq0.push_back(8'($urandom));
      if (rq1.size() < 3) rq1.push_back(8'($urandom));
    end
    drive();
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    stim_update();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_req_drain(input int limit);
    for (int i = 0; i < limit && (rq0.size() + rq1.size()) > 0; i++) cycle();
    chk("req_drain_left", 32'(rq0.size() + rq1.size()), 32'd0);
    run(2);
  endtask

  task automatic wait_fifo_drain(input int limit);
    rd_pct = 100;
    drive();
    for (int i = 0; i < limit && fifo_q.size() > 0; i++) cycle();
    chk("fifo_drain_left", 32'(fifo_q.size()), 32'd0);
    rd_pct = 0;
    drive();
  endtask

  task automatic reset_sync();
    rst = 1'b1;
    model_reset();
    rq0.delete();
    rq1.delete();
    en0 = 0; en1 = 0;
    drive();
    run(2);
    rst = 1'b0;
  endtask

  // Monitor: pops one expected cycle per falling edge and a beat record
  // whenever the arbiter presents a write.
  initial begin
    cyc_t  e;
    beat_t b;
    forever begin
      @(negedge clk);
      #1;
      if (cyc_q.size() == 0) continue;
      e = cyc_q.pop_front();
      chk("gnt0", 32'(gnt0), 32'(e.g0));
      chk("gnt1", 32'(gnt1), 32'(e.g1));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("full", 32'(full), 32'(e.full));
      chk("wr_en", 32'(wr_en), 32'(e.beat));
      chk("wdata_mux", 32'(wdata), 32'(e.wd));
      chk("fifo_wr_error", 32'(wr_error), 32'd0);
      if (wr_en) begin
        if (beat_q.size() == 0) begin
          chk("beat_q_depth", 32'(beat_q.size()), 32'd1);
        end else begin
          b = beat_q.pop_front();
          chk("beat_data", 32'(wdata), 32'(b.data));
          chk("beat_src", 32'(gnt1), 32'(b.src));
        end
      end else if (e.beat && beat_q.size() > 0) begin
        b = beat_q.pop_front();
      end
    end
  end

  initial begin
    req0 = 0; req1 = 0; wdata0 = '0; wdata1 = '0; rd_en = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_fifo_empty", 32'(empty), 32'd1);
    run(2);
    rst = 1'b0;

    // Single requester, ten words: bursts 4/4/2 with seamless re-grants.
    en0 = 1;
    for (int i = 1; i <= 10; i++) rq0.push_back(8'(i));
    drive();
    wait_req_drain(40);
    chk("solo_fifo_count", 32'(fifo_q.size()), 32'd10);
    wait_fifo_drain(30);

    // Both requesters continuously active: alternating 4-beat bursts.
    reset_sync();
    rd_pct = 100;
    en0 = 1; en1 = 1;
    for (int i = 0; i < 24; i++) begin
      rq0.push_back(8'(i));
      rq1.push_back(8'(8'h80 + i));
    end
    drive();
    run(30);
    en0 = 0; en1 = 0;
    rq0.delete(); rq1.delete();
    drive();
    run(2);
    wait_fifo_drain(30);

    // Nearly full FIFO: one beat, stall while full, resume after one read.
    reset_sync();
    en0 = 1;
    for (int i = 0; i < 15; i++) rq0.push_back(8'(8'h40 + i));
    drive();
    wait_req_drain(40);
    chk("prefill_count", 32'(fifo_q.size()), 32'd15);
    en1 = 1;
    for (int i = 0; i < 3; i++) rq1.push_back(8'(8'hC0 + i));
    drive();
    run(6);
    rd_pct = 100;
    drive();
    run(1);
    rd_pct = 0;
    drive();
    run(4);
    wait_fifo_drain(40);
    wait_req_drain(20);
    wait_fifo_drain(20);

    // Requester 0 runs dry after two beats while requester 1 waits.
    reset_sync();
    rd_pct = 100;
    en0 = 1; en1 = 1;
    rq0.push_back(8'hA0); rq0.push_back(8'hA1);
    for (int i = 0; i < 6; i++) rq1.push_back(8'(8'hB0 + i));
    drive();
    wait_req_drain(30);
    wait_fifo_drain(20);

    // Reset between edges during SERVE1, then a tie after release.
    reset_sync();
    rd_pct = 100;
    en1 = 1;
    for (int i = 0; i < 10; i++) rq1.push_back(8'(8'hD0 + i));
    drive();
    run(3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_gnt1", 32'(gnt1), 32'd0);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    model_reset();
    en0 = 1;
    for (int i = 0; i < 6; i++) rq0.push_back(8'(8'hE0 + i));
    drive();
    run(2);
    rst = 1'b0;
    wait_req_drain(60);
    wait_fifo_drain(20);

    // Randomised traffic with light and heavy downstream backpressure.
    reset_sync();
    rnd_mode = 1;
    rd_pct = 60;
    drive();
    run(1200);
    rd_pct = 20;
    run(800);
    rnd_mode = 0;
    en0 = 0; en1 = 0;
    rq0.delete(); rq1.delete();
    drive();
    run(2);
    wait_fifo_drain(60);

    @(negedge clk);
    #2;
    chk("beat_q_leftover", 32'(beat_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
